// File: rtl/pong_sprite_renderer.sv
// Pong object renderer: two paddles plus a bitmapped ball that flashes after a hit.
// Two-cycle pipeline from x/y/pixel_valid to game_on/game_rgb/out_valid; no backpressure.
module pong_sprite_renderer #(
   parameter int          SCREEN_W      = 640,
   parameter int          PADDLE_W      = 5,
   parameter int          PADDLE_H      = 50,
   parameter int          PADDLE_MARGIN = 10,
   parameter int          BALL_SIZE     = 8,
   parameter int          FLASH_FRAMES  = 8,
   parameter logic [11:0] PADDLE_RGB    = 12'hFFF,
   parameter logic [11:0] BALL_RGB      = 12'hFFF,
   parameter logic [11:0] FLASH_RGB     = 12'hF00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        pixel_valid,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [9:0]  paddle_left_pos,
   input  logic [9:0]  paddle_right_pos,
   input  logic [9:0]  ball_pos_x,
   input  logic [9:0]  ball_pos_y,
   input  logic        hit_pulse,
   output logic        game_on,
   output logic [11:0] game_rgb,
   output logic        out_valid
);

   localparam logic [10:0] LEFT_X0   = 11'(PADDLE_MARGIN);
   localparam logic [10:0] LEFT_X1   = 11'(PADDLE_MARGIN + PADDLE_W);
   localparam logic [10:0] RIGHT_X0  = 11'(SCREEN_W - PADDLE_MARGIN - PADDLE_W);
   localparam logic [10:0] RIGHT_X1  = 11'(SCREEN_W - PADDLE_MARGIN);
   localparam logic [10:0] PAD_H     = 11'(PADDLE_H);
   localparam logic [10:0] BALL_SZ   = 11'(BALL_SIZE);
   localparam logic [7:0]  FLASH_LD  = 8'(FLASH_FRAMES);

   function automatic logic [7:0] ball_row(input logic [2:0] r);
      case (r)
         3'd0, 3'd7: ball_row = 8'b0011_1100;
         3'd1, 3'd6: ball_row = 8'b0111_1110;
         default:    ball_row = 8'b1111_1111;
      endcase
   endfunction

   logic [9:0]  pl_q, pr_q, bx_q, by_q;
   logic [7:0]  flash_cnt;
   logic        s1_vld, s1_paddle, s1_ball, s1_flash;
   logic [2:0]  s1_row, s1_col;

   // Positions only move at frame boundaries so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pl_q <= '0;
         pr_q <= '0;
         bx_q <= '0;
         by_q <= '0;
      end else if (frame_start) begin
         pl_q <= paddle_left_pos;
         pr_q <= paddle_right_pos;
         bx_q <= ball_pos_x;
         by_q <= ball_pos_y;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         flash_cnt <= '0;
      else if (hit_pulse)
         flash_cnt <= FLASH_LD;
      else if (frame_start && flash_cnt != 8'd0)
         flash_cnt <= flash_cnt - 8'd1;
   end

   // 11-bit compares keep pos+height from wrapping past 1023.
   logic [10:0] x11, y11, pl11, pr11, bx11, by11;
   logic        left_hit, right_hit, ball_box;
   logic [2:0]  ball_r, ball_c;

   always_comb begin
      x11  = {1'b0, x};
      y11  = {1'b0, y};
      pl11 = {1'b0, pl_q};
      pr11 = {1'b0, pr_q};
      bx11 = {1'b0, bx_q};
      by11 = {1'b0, by_q};
      left_hit  = (x11 >= LEFT_X0) && (x11 < LEFT_X1) &&
                  (y11 >= pl11) && (y11 < pl11 + PAD_H);
      right_hit = (x11 >= RIGHT_X0) && (x11 < RIGHT_X1) &&
                  (y11 >= pr11) && (y11 < pr11 + PAD_H);
      ball_box  = (x11 >= bx11) && (x11 < bx11 + BALL_SZ) &&
                  (y11 >= by11) && (y11 < by11 + BALL_SZ);
      ball_r = y[2:0] - by_q[2:0];
      ball_c = x[2:0] - bx_q[2:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         s1_paddle <= 1'b0;
         s1_ball   <= 1'b0;
         s1_flash  <= 1'b0;
         s1_row    <= '0;
         s1_col    <= '0;
      end else begin
         s1_vld    <= pixel_valid;
         s1_paddle <= pixel_valid && (left_hit || right_hit);
         s1_ball   <= pixel_valid && ball_box;
         s1_flash  <= (flash_cnt != 8'd0);
         s1_row    <= ball_r;
         s1_col    <= ball_c;
      end
   end

   logic        ball_lit;
   logic        on_d;
   logic [11:0] rgb_d;
   logic [7:0]  row_bits;

   always_comb begin
      row_bits = ball_row(s1_row);
      ball_lit = s1_ball && row_bits[3'd7 - s1_col];
      on_d     = 1'b0;
      rgb_d    = 12'h000;
      if (ball_lit) begin
         on_d  = 1'b1;
         rgb_d = s1_flash ? FLASH_RGB : BALL_RGB;
      end else if (s1_paddle) begin
         on_d  = 1'b1;
         rgb_d = PADDLE_RGB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         game_on   <= 1'b0;
         game_rgb  <= 12'h000;
         out_valid <= 1'b0;
      end else begin
         game_on   <= on_d;
         game_rgb  <= rgb_d;
         out_valid <= s1_vld;
      end
   end

endmodule

// File: tb/tb_pong_sprite_renderer.sv
// Randomized and directed bench for pong_sprite_renderer against a pixel-rule model.
module tb_pong_sprite_renderer;

   localparam int FLASH_N = 3;
   localparam int SW = 640, PM = 10, PW = 5, PH = 50, BS = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        frame_start = 1'b0, pixel_valid = 1'b0, hit_pulse = 1'b0;
   logic [9:0]  x = '0, y = '0;
   logic [9:0]  paddle_left_pos = '0, paddle_right_pos = '0;
   logic [9:0]  ball_pos_x = '0, ball_pos_y = '0;
   logic        game_on, out_valid;
   logic [11:0] game_rgb;

   int errors = 0;
   int checks = 0;
   int m_pl, m_pr, m_bx, m_by, m_cnt;
   bit [7:0] bmp [8];

   always #5 clk = ~clk;

   pong_sprite_renderer #(.FLASH_FRAMES(FLASH_N)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
      .x(x), .y(y), .paddle_left_pos(paddle_left_pos), .paddle_right_pos(paddle_right_pos),
      .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y), .hit_pulse(hit_pulse),
      .game_on(game_on), .game_rgb(game_rgb), .out_valid(out_valid)
   );

   // Expected {game_on, game_rgb} for one pixel from the drawing rules.
   function automatic logic [12:0] model(input int px, input int py, input bit v);
      int r, c;
      bit lit, pad;
      if (!v) return 13'h0;
      lit = 0;
      if (px >= m_bx && px < m_bx + BS && py >= m_by && py < m_by + BS) begin
         r = py - m_by;
         c = px - m_bx;
         lit = bmp[r][7 - c];
      end
      if (lit) return {1'b1, (m_cnt > 0) ? 12'hF00 : 12'hFFF};
      pad = (px >= PM && px < PM + PW && py >= m_pl && py < m_pl + PH) ||
            (px >= SW - PM - PW && px < SW - PM && py >= m_pr && py < m_pr + PH);
      if (pad) return {1'b1, 12'hFFF};
      return 13'h0;
   endfunction

   task automatic frame(input int pl, input int pr, input int bx, input int by, input bit hit);
      paddle_left_pos = 10'(pl); paddle_right_pos = 10'(pr);
      ball_pos_x = 10'(bx); ball_pos_y = 10'(by);
      pixel_valid = 1'b0; frame_start = 1'b1; hit_pulse = hit;
      @(posedge clk); #1;
      frame_start = 1'b0; hit_pulse = 1'b0;
      m_pl = pl; m_pr = pr; m_bx = bx; m_by = by;
      if (hit) m_cnt = FLASH_N;
      else if (m_cnt > 0) m_cnt--;
   endtask

   task automatic hit_only();
      hit_pulse = 1'b1;
      @(posedge clk); #1;
      hit_pulse = 1'b0;
      m_cnt = FLASH_N;
   endtask

   task automatic probe(input int px, input int py, input bit v,
                        output logic [12:0] got, output logic gv);
      x = 10'(px); y = 10'(py); pixel_valid = v;
      @(posedge clk); #1;
      @(posedge clk); #1;
      got = {game_on, game_rgb};
      gv = out_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if ({game_on, game_rgb, out_valid} !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0", {game_on, game_rgb, out_valid});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_pl = 0; m_pr = 0; m_bx = 0; m_by = 0; m_cnt = 0;
   endtask

   task automatic test_left_paddle();
      logic [12:0] g; logic gv;
      frame(100, 300, 300, 200, 0);
      probe(10, 100, 1, g, gv);
      checks++;
      if (g !== 13'h1FFF || gv !== 1'b1) begin
         errors++; $display("FAIL left_paddle_on got=%h/%b exp=1fff/1", g, gv);
      end
      probe(15, 100, 1, g, gv);
      checks++;
      if (g !== 13'h0) begin errors++; $display("FAIL left_paddle_x15 got=%h exp=0", g); end
      probe(10, 150, 1, g, gv);
      checks++;
      if (g !== 13'h0) begin errors++; $display("FAIL left_paddle_y150 got=%h exp=0", g); end
      probe(10, 120, 0, g, gv);
      checks++;
      if ({g, gv} !== 14'h0) begin errors++; $display("FAIL invalid_pixel got=%h exp=0", {g, gv}); end
   endtask

   task automatic test_ball_bitmap();
      logic [12:0] g, e; logic gv;
      frame(100, 300, 300, 200, 0);
      probe(300, 200, 1, g, gv);
      checks++;
      if (g !== 13'h0) begin errors++; $display("FAIL ball_corner got=%h exp=0", g); end
      probe(302, 200, 1, g, gv);
      checks++;
      if (g[12] !== 1'b1) begin errors++; $display("FAIL ball_302_200 got=%b exp=1", g[12]); end
      probe(300, 202, 1, g, gv);
      checks++;
      if (g[12] !== 1'b1) begin errors++; $display("FAIL ball_300_202 got=%b exp=1", g[12]); end
      for (int r = -1; r <= 8; r++)
         for (int c = -1; c <= 8; c++) begin
            probe(300 + c, 200 + r, 1, g, gv);
            e = model(300 + c, 200 + r, 1);
            checks++;
            if (g !== e) begin
               errors++; $display("FAIL ball_scan r=%0d c=%0d got=%h exp=%h", r, c, g, e);
            end
         end
   endtask

   task automatic test_shadow();
      logic [12:0] g; logic gv;
      frame(100, 300, 300, 200, 0);
      ball_pos_x = 10'd400;
      probe(402, 200, 1, g, gv);
      checks++;
      if (g[12] !== 1'b0) begin errors++; $display("FAIL shadow_hold_new got=%b exp=0", g[12]); end
      probe(302, 200, 1, g, gv);
      checks++;
      if (g[12] !== 1'b1) begin errors++; $display("FAIL shadow_hold_old got=%b exp=1", g[12]); end
      frame(100, 300, 400, 200, 0);
      probe(402, 200, 1, g, gv);
      checks++;
      if (g[12] !== 1'b1) begin errors++; $display("FAIL shadow_update got=%b exp=1", g[12]); end
   endtask

   task automatic test_flash();
      logic [12:0] g; logic gv;
      frame(100, 300, 300, 200, 0);
      hit_only();
      for (int f = 0; f < 4; f++) begin
         if (f > 0) frame(100, 300, 300, 200, 0);
         probe(302, 200, 1, g, gv);
         checks++;
         if (g !== {1'b1, (f < 3) ? 12'hF00 : 12'hFFF}) begin
            errors++; $display("FAIL flash_frame%0d got=%h exp=%h", f, g, {1'b1, (f < 3) ? 12'hF00 : 12'hFFF});
         end
      end
      frame(100, 300, 300, 200, 1);
      for (int f = 0; f < 3; f++) begin
         if (f > 0) frame(100, 300, 300, 200, 0);
         probe(303, 201, 1, g, gv);
         checks++;
         if (g !== 13'h1F00) begin errors++; $display("FAIL flash_coincide%0d got=%h exp=1f00", f, g); end
      end
      frame(100, 300, 300, 200, 0);
      probe(303, 201, 1, g, gv);
      checks++;
      if (g !== 13'h1FFF) begin errors++; $display("FAIL flash_coincide_end got=%h exp=1fff", g); end
      frame(100, 300, 300, 200, 0);
      hit_only();
      frame(100, 300, 300, 200, 0);
      hit_only();
      frame(100, 300, 300, 200, 0);
      frame(100, 300, 300, 200, 0);
      probe(303, 201, 1, g, gv);
      checks++;
      if (g !== 13'h1F00) begin errors++; $display("FAIL flash_restart got=%h exp=1f00", g); end
   endtask

   task automatic test_wrap();
      logic [12:0] g; logic gv;
      frame(100, 1000, 300, 200, 0);
      probe(628, 5, 1, g, gv);
      checks++;
      if (g[12] !== 1'b0) begin errors++; $display("FAIL wrap_y5 got=%b exp=0", g[12]); end
      probe(628, 1010, 1, g, gv);
      checks++;
      if (g !== 13'h1FFF) begin errors++; $display("FAIL wrap_y1010 got=%h exp=1fff", g); end
   endtask

   task automatic test_async_reset();
      logic [12:0] g; logic gv;
      frame(100, 300, 300, 200, 0);
      probe(10, 100, 1, g, gv);
      checks++;
      if (g[12] !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", g[12]); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({game_on, game_rgb, out_valid} !== 14'h0) begin
         errors++; $display("FAIL areset_immediate got=%h exp=0", {game_on, game_rgb, out_valid});
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_pl = 0; m_pr = 0; m_bx = 0; m_by = 0; m_cnt = 0;
      @(posedge clk); #1;
      probe(10, 100, 1, g, gv);
      checks++;
      if (g[12] !== 1'b0) begin errors++; $display("FAIL areset_no_draw got=%b exp=0", g[12]); end
      frame(100, 300, 300, 200, 0);
      probe(10, 100, 1, g, gv);
      checks++;
      if (g !== 13'h1FFF) begin errors++; $display("FAIL areset_redraw got=%h exp=1fff", g); end
   endtask

   function automatic void pick(output int px, output int py);
      case ($urandom_range(0, 3))
         0: begin px = m_bx + int'($urandom_range(0, 9)) - 1; py = m_by + int'($urandom_range(0, 9)) - 1; end
         1: begin px = int'($urandom_range(9, 15)); py = m_pl + int'($urandom_range(0, 51)) - 1; end
         2: begin px = int'($urandom_range(624, 630)); py = m_pr + int'($urandom_range(0, 51)) - 1; end
         default: begin px = int'($urandom_range(0, 1023)); py = int'($urandom_range(0, 1023)); end
      endcase
      px = px & 1023;
      py = py & 1023;
   endfunction

   task automatic test_random();
      logic [12:0] g, e; logic gv;
      int px, py;
      bit v;
      for (int it = 0; it < 30; it++) begin
         frame($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 639),
               $urandom_range(0, 479), ($urandom_range(0, 3) == 0));
         for (int k = 0; k < 6; k++) begin
            pick(px, py);
            v = ($urandom_range(0, 7) != 0);
            probe(px, py, v, g, gv);
            e = model(px, py, v);
            checks++;
            if (g !== e || gv !== v) begin
               errors++; $display("FAIL random px=%0d py=%0d got=%h/%b exp=%h/%b", px, py, g, gv, e, v);
            end
         end
      end
   endtask

   // One pixel per cycle; each result must appear exactly two edges after it is driven.
   task automatic test_back_to_back();
      logic [13:0] exp_q[$];
      logic [13:0] e;
      int px, py;
      bit v;
      frame($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 639),
            $urandom_range(0, 479), 1);
      for (int i = 0; i <= 60; i++) begin
         if (i < 60) begin
            pick(px, py);
            v = ($urandom_range(0, 5) != 0);
            x = 10'(px); y = 10'(py); pixel_valid = v;
            exp_q.push_back({model(px, py, v), v});
         end else begin
            pixel_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (i >= 1) begin
            e = exp_q.pop_front();
            checks++;
            if ({game_on, game_rgb, out_valid} !== e) begin
               errors++; $display("FAIL stream i=%0d got=%h exp=%h", i - 1, {game_on, game_rgb, out_valid}, e);
            end
         end
      end
   endtask

   initial begin
      bmp = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};
      #1;
      test_reset();
      test_left_paddle();
      test_ball_bitmap();
      test_shadow();
      test_flash();
      test_wrap();
      test_async_reset();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pong_sprite_renderer.md
PONG_SPRITE_RENDERER -- requirements
Module: pong_sprite_renderer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, the horizontal active width in pixels.
REQ-002 SHALL have parameter PADDLE_W, default 5, the paddle width in pixels.
REQ-003 SHALL have parameter PADDLE_H, default 50, the paddle height in pixels.
REQ-004 SHALL have parameter PADDLE_MARGIN, default 10, the gap in pixels between each screen edge and its paddle.
REQ-005 SHALL have parameter BALL_SIZE, default 8, the ball sprite edge in pixels; the legal range is 1..8.
REQ-006 SHALL have parameter FLASH_FRAMES, default 8, the number of frames the ball flashes after a hit; the legal range is 1..255.
REQ-007 SHALL have parameters PADDLE_RGB, BALL_RGB, FLASH_RGB, defaults 12'hFFF, 12'hFFF, 12'hF00, giving the object colours.
REQ-008 Ports: clk  in  1  sole clock, rising edge.
REQ-009 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-010 Ports: frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-011 Ports: pixel_valid  in  1  the current x/y is in the active video area.
REQ-012 Ports: x, y  in  10 each  current pixel coordinate.
REQ-013 Ports: paddle_left_pos, paddle_right_pos  in  10 each  top row of each paddle.
REQ-014 Ports: ball_pos_x, ball_pos_y  in  10 each  top-left corner of the ball.
REQ-015 Ports: hit_pulse  in  1  one-cycle pulse on a ball/paddle collision.
REQ-016 Ports: game_on  out  1  an object pixel is drawn.
REQ-017 Ports: game_rgb  out  12  pixel colour.
REQ-018 Ports: out_valid  out  1  pixel_valid delayed to align with game_on/game_rgb.

Function
REQ-019 Position inputs SHALL be captured into shadow registers only on cycles where frame_start=1; all drawing uses the shadow values, so a frame never tears.
REQ-020 Output latency SHALL be exactly 2 cycles from x/y/pixel_valid to game_on/game_rgb/out_valid.
- Stage 1 registers region hits and ball offsets.
- Stage 2 registers the bitmap lookup and colour.
REQ-021 All region compares SHALL use 11-bit arithmetic, so that pos+PADDLE_H or pos+BALL_SIZE never wraps.
- Example: paddle_left_pos=1000 covers y 1000..1023 only.
REQ-022 The left paddle region SHALL be PADDLE_MARGIN <= x < PADDLE_MARGIN+PADDLE_W, and pos <= y < pos+PADDLE_H.
REQ-023 The right paddle region SHALL be SCREEN_W-PADDLE_MARGIN-PADDLE_W <= x < SCREEN_W-PADDLE_MARGIN, with the same y rule as REQ-022.
REQ-024 The ball box SHALL be bx <= x < bx+BALL_SIZE and by <= y < by+BALL_SIZE.
- Row r = y-by, column c = x-bx.
- A pixel is lit iff bit (7-c) of bitmap row r is 1.
- Rows 0..7: 00111100, 01111110, 11111111, 11111111, 11111111, 11111111, 01111110, 00111100.
REQ-025 Drawing priority SHALL be: lit ball pixel, then paddle, then background (game_on=0, game_rgb=12'h000).
REQ-026 When pixel_valid=0, the corresponding output SHALL be game_on=0, game_rgb=12'h000, out_valid=0.
REQ-027 Flash counter (8 bits) SHALL behave as follows:
- hit_pulse loads FLASH_FRAMES.
- Otherwise, frame_start decrements the counter when it is nonzero.
- When hit_pulse and frame_start coincide, the load wins.
REQ-028 A lit ball pixel SHALL use FLASH_RGB while the counter is nonzero and BALL_RGB otherwise; the counter value used is the one registered at stage 1.
REQ-029 hit_pulse during a flash SHALL restart the count at FLASH_FRAMES.

Reset
REQ-030 rst_n=0 SHALL immediately clear the following, independent of clk:
- all shadow registers, flash counter and pipeline registers to 0;
- game_on=0, game_rgb=12'h000, out_valid=0.
REQ-031 After rst_n rises, the shadow registers SHALL hold 0 until the first frame_start; reset mid-frame discards in-flight pixels.

Verification
REQ-032 Left paddle:
- Stimulus: frame_start with paddle_left_pos=100; pixel_valid=1, x=10, y=100.
- Response: two cycles later game_on=1, game_rgb=12'hFFF.
- Also: x=15 or y=150 -> game_on=0.
REQ-033 Ball bitmap:
- Stimulus: ball_pos=(300,200) latched; x=300,y=200.
- Response: game_on=0 (corner).
- Also: x=302,y=200 -> game_on=1; x=300,y=202 -> game_on=1.
REQ-034 Shadow latching:
- Stimulus: change ball_pos_x from 300 to 400 mid-frame, then probe x=400.
- Response: game_on=0 until the next frame_start, then the ball is drawn at 400.
REQ-035 Flash counter with FLASH_FRAMES=3:
- Stimulus: hit_pulse, then successive frame_starts.
- Response: ball pixels are 12'hF00 for 3 frame_starts, then 12'hFFF.
- Also: hit_pulse coinciding with frame_start leaves the counter at 3.
REQ-036 Wrap guard:
- Stimulus: paddle_right_pos=1000; x=628, y=5.
- Response: game_on=0.
- Also: y=1010 -> game_on=1.
REQ-037 Async reset:
- Stimulus: assert rst_n=0 between clock edges while game_on=1.
- Response: outputs go to 0 without a clock edge.
- Also: no object is drawn until after the next frame_start.
